// File: rtl/lcd_msg_scheduler.sv
// Arbitrates the shared LCD controller between message codes and score updates.
// Define LCD_SCHED_RR_EN for round-robin arbitration on ties; otherwise messages win.
module lcd_msg_scheduler #(
    parameter int MSG_W        = 3,
    parameter int SCORE_W      = 8,
    parameter int HOLD_CYCLES  = 50,
    parameter int BUSY_TIMEOUT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               msg_req,
    input  logic [MSG_W-1:0]   msg_code,
    input  logic               score_req,
    input  logic [SCORE_W-1:0] score_val,
    input  logic               lcd_busy,
    output logic               lcd_start,
    output logic               lcd_sel,
    output logic [SCORE_W-1:0] lcd_data,
    output logic               grant_msg,
    output logic               grant_score,
    output logic               timeout_err
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    // Requests are registered on arrival, so lcd_start follows the sampling edge by two edges.
    logic               msg_req_q, score_req_q;
    logic [MSG_W-1:0]   msg_code_q;
    logic [SCORE_W-1:0] score_val_q;

    logic               msg_pend, score_pend;
    logic [MSG_W-1:0]   msg_hold;
    logic [SCORE_W-1:0] score_hold;

    logic               msg_wins;
    logic               pick_msg, pick_score;
    logic               timeout_set;

`ifdef LCD_SCHED_RR_EN
    logic last_score;

    always_ff @(posedge clk) begin
        if (reset)
            last_score <= 1'b1;
        else if (pick_msg || pick_score)
            last_score <= pick_score;
    end

    assign msg_wins = last_score;
`else
    assign msg_wins = 1'b1;
`endif

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pick_msg    = 1'b0;
        pick_score  = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (msg_pend || score_pend) begin
                    if (msg_pend && (!score_pend || msg_wins))
                        pick_msg = 1'b1;
                    else
                        pick_score = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (lcd_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == BUSY_LAST) begin
                    // Controller never acknowledged; drop this transfer without retry.
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!lcd_busy) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST)
                    state_d = IDLE;
                else
                    cnt_d = cnt + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            msg_req_q   <= 1'b0;
            score_req_q <= 1'b0;
            msg_code_q  <= '0;
            score_val_q <= '0;
            msg_pend    <= 1'b0;
            score_pend  <= 1'b0;
            msg_hold    <= '0;
            score_hold  <= '0;
            lcd_start   <= 1'b0;
            lcd_sel     <= 1'b0;
            lcd_data    <= '0;
            grant_msg   <= 1'b0;
            grant_score <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            msg_req_q   <= msg_req;
            score_req_q <= score_req;
            if (msg_req)
                msg_code_q <= msg_code;
            if (score_req)
                score_val_q <= score_val;

            // A fresh request wins over the clear from a same-cycle grant.
            if (msg_req_q) begin
                msg_pend <= 1'b1;
                msg_hold <= msg_code_q;
            end else if (pick_msg) begin
                msg_pend <= 1'b0;
            end
            if (score_req_q) begin
                score_pend <= 1'b1;
                score_hold <= score_val_q;
            end else if (pick_score) begin
                score_pend <= 1'b0;
            end

            lcd_start   <= pick_msg || pick_score;
            grant_msg   <= pick_msg;
            grant_score <= pick_score;
            if (pick_msg) begin
                lcd_sel  <= 1'b0;
                lcd_data <= SCORE_W'(msg_hold);
            end else if (pick_score) begin
                lcd_sel  <= 1'b1;
                lcd_data <= score_hold;
            end
            if (timeout_set)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Bench for lcd_msg_scheduler: timestamp model checked every cycle plus literal spot checks.
module tb_lcd_msg_scheduler;

    localparam int H = 6;
    localparam int T = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       msg_req = 1'b0;
    logic [2:0] msg_code = '0;
    logic       score_req = 1'b0;
    logic [7:0] score_val = '0;
    logic       lcd_busy = 1'b0;
    logic       lcd_start, lcd_sel, grant_msg, grant_score, timeout_err;
    logic [7:0] lcd_data;
    logic       lcd_dead = 1'b0;

    lcd_msg_scheduler #(
        .MSG_W(3), .SCORE_W(8), .HOLD_CYCLES(H), .BUSY_TIMEOUT(T), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .msg_req(msg_req), .msg_code(msg_code),
        .score_req(score_req), .score_val(score_val),
        .lcd_busy(lcd_busy),
        .lcd_start(lcd_start), .lcd_sel(lcd_sel), .lcd_data(lcd_data),
        .grant_msg(grant_msg), .grant_score(grant_score), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // LCD controller stand-in: busy one edge after it sees start, for three edges.
    initial forever begin
        @(posedge clk);
        if (lcd_start && !lcd_dead && !reset) begin
            @(posedge clk);
            #2 lcd_busy = 1'b1;
            repeat (3) @(posedge clk);
            #2 lcd_busy = 1'b0;
        end
    end

    // Model: pending entries plus timestamps of the current transfer.
    int         n = 0;
    logic       a_m, a_s, p_m, p_s, last_s, inflight, m_gm, m_gs;
    logic [2:0] a_mv, p_mv;
    logic [7:0] a_sv, p_sv;
    int         free_at, t_issue, t_busy;
    logic       e_start, e_gm, e_gs, e_sel, e_to;
    logic [7:0] e_data;

    initial begin
        {a_m, a_s, p_m, p_s, inflight, m_gm, m_gs} = '0;
        last_s = 1'b1;
        a_mv = '0; p_mv = '0; a_sv = '0; p_sv = '0;
        free_at = 0; t_issue = 0; t_busy = -1;
        {e_start, e_gm, e_gs, e_sel, e_to} = '0;
        e_data = '0;
        forever begin
            @(posedge clk);
            n++;
            if (reset) begin
                {a_m, a_s, p_m, p_s, inflight} = '0;
                last_s = 1'b1;
                a_mv = '0; p_mv = '0; a_sv = '0; p_sv = '0;
                free_at = n + 1; t_busy = -1;
                {e_start, e_gm, e_gs, e_sel, e_to} = '0;
                e_data = '0;
            end else begin
                m_gm = 1'b0; m_gs = 1'b0;
                if (!inflight && n >= free_at && (p_m || p_s)) begin
                    if (p_m && p_s) begin
`ifdef LCD_SCHED_RR_EN
                        m_gm = last_s;
`else
                        m_gm = 1'b1;
`endif
                    end else begin
                        m_gm = p_m;
                    end
                    m_gs = !m_gm;
                    last_s = m_gs;
                    inflight = 1'b1; t_issue = n; t_busy = -1;
                    e_sel  = m_gs;
                    e_data = m_gm ? {5'b0, p_mv} : p_sv;
                end else if (inflight) begin
                    if (t_busy < 0) begin
                        if (n >= t_issue + 2 && lcd_busy) t_busy = n;
                        else if (n == t_issue + T + 1) begin
                            e_to = 1'b1; inflight = 1'b0; free_at = n + 1;
                        end
                    end else if (!lcd_busy) begin
                        inflight = 1'b0; free_at = n + H + 1;
                    end
                end
                e_start = m_gm || m_gs; e_gm = m_gm; e_gs = m_gs;
                if (a_m) begin p_m = 1'b1; p_mv = a_mv; end else if (m_gm) p_m = 1'b0;
                if (a_s) begin p_s = 1'b1; p_sv = a_sv; end else if (m_gs) p_s = 1'b0;
                a_m = msg_req; a_s = score_req;
                if (msg_req) a_mv = msg_code;
                if (score_req) a_sv = score_val;
            end
        end
    end

    // Literal expectations posted by the stimulus, consumed at the next falling edge.
    int          lit_seq = 0;
    int          lit_seen = 0;
    string       lit_tag = "";
    logic [12:0] lit_vec = '0;
    logic [12:0] dut_vec, mdl_vec;
    assign dut_vec = {lcd_start, grant_msg, grant_score, lcd_sel, lcd_data, timeout_err};
    assign mdl_vec = {e_start, e_gm, e_gs, e_sel, e_data, e_to};

    initial forever begin
        @(negedge clk);
        if (n > 0) begin
            n_checks++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL model cycle %0d: got start/gm/gs/sel/data/to=%b required %b",
                         n, dut_vec, mdl_vec);
            end
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            n_checks++;
            if (dut_vec !== lit_vec) begin
                n_fail++;
                $display("FAIL %s: got start/gm/gs/sel/data/to=%b required %b",
                         lit_tag, dut_vec, lit_vec);
            end
        end
    end

    function automatic logic [12:0] pk(input logic st, gm, gs, sel,
                                       input logic [7:0] d, input logic to);
        return {st, gm, gs, sel, d, to};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string tag, input logic [12:0] v);
        lit_tag = tag;
        lit_vec = v;
        lit_seq++;
    endtask

    task automatic wait_start(input int limit);
        int i = 0;
        logic seen = 1'b0;
        while (!seen && i < limit) begin
            tick();
            seen = lcd_start;
            i++;
        end
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;

        // 1: idle for 100 cycles
        repeat (100) tick();
        lit("t1_idle", pk(0, 0, 0, 0, 8'h00, 0));

        // 2: single message, two-edge latency
        msg_req = 1'b1; msg_code = 3'd5;
        tick();
        msg_req = 1'b0;
        lit("t2_edge_k", pk(0, 0, 0, 0, 8'h00, 0));
        tick();
        lit("t2_edge_k1", pk(0, 0, 0, 0, 8'h00, 0));
        tick();
        lit("t2_edge_k2", pk(1, 1, 0, 0, 8'h05, 0));
        tick();
        lit("t2_pulse_end", pk(0, 0, 0, 0, 8'h05, 0));
        repeat (30) tick();

        // 3: tie twice; message first, score H cycles after busy falls
        for (int rep = 0; rep < 2; rep++) begin
            msg_req = 1'b1; msg_code = 3'd2;
            score_req = 1'b1; score_val = 8'd42;
            tick();
            msg_req = 1'b0; score_req = 1'b0;
            wait_start(10);
            lit("t3_tie_msg", pk(1, 1, 0, 0, 8'h02, 0));
            repeat (12) tick();
            lit("t3_hold_gap", pk(0, 0, 0, 0, 8'h02, 0));
            tick();
            lit("t3_score_next", pk(1, 0, 1, 1, 8'd42, 0));
            repeat (25) tick();
        end

        // 3b: tie arising after a message grant
        msg_req = 1'b1; msg_code = 3'd4;
        tick();
        msg_req = 1'b0;
        wait_start(10);
        lit("t3b_first", pk(1, 1, 0, 0, 8'h04, 0));
        repeat (7) tick();
        msg_req = 1'b1; msg_code = 3'd6;
        score_req = 1'b1; score_val = 8'd55;
        tick();
        msg_req = 1'b0; score_req = 1'b0;
        wait_start(40);
`ifdef LCD_SCHED_RR_EN
        lit("t3b_tie_winner", pk(1, 0, 1, 1, 8'd55, 0));
        wait_start(40);
        lit("t3b_tie_loser", pk(1, 1, 0, 0, 8'h06, 0));
`else
        lit("t3b_tie_winner", pk(1, 1, 0, 0, 8'h06, 0));
        wait_start(40);
        lit("t3b_tie_loser", pk(1, 0, 1, 1, 8'd55, 0));
`endif
        repeat (30) tick();

        // 4: two score updates during HOLD collapse into one transfer
        msg_req = 1'b1; msg_code = 3'd1;
        tick();
        msg_req = 1'b0;
        wait_start(10);
        repeat (7) tick();
        score_req = 1'b1; score_val = 8'd10;
        tick();
        score_req = 1'b0;
        tick();
        score_req = 1'b1; score_val = 8'd20;
        tick();
        score_req = 1'b0;
        wait_start(40);
        lit("t4_latest_wins", pk(1, 0, 1, 1, 8'd20, 0));
        repeat (30) tick();
        lit("t4_no_second", pk(0, 0, 0, 1, 8'd20, 0));

        // 5: busy never rises -> timeout, then the pending score still goes out
        lcd_dead = 1'b1;
        msg_req = 1'b1; msg_code = 3'd7;
        tick();
        msg_req = 1'b0;
        wait_start(10);
        lit("t5_issue", pk(1, 1, 0, 0, 8'h07, 0));
        score_req = 1'b1; score_val = 8'd99;
        tick();
        score_req = 1'b0;
        repeat (9) tick();
        lit("t5_before_to", pk(0, 0, 0, 0, 8'h07, 0));
        tick();
        lit("t5_timeout", pk(0, 0, 0, 0, 8'h07, 1));
        lcd_dead = 1'b0;
        tick();
        lit("t5_next_issue", pk(1, 0, 1, 1, 8'd99, 1));
        repeat (30) tick();

        // 6: reset during WAIT_DONE with a score pending
        msg_req = 1'b1; msg_code = 3'd3;
        tick();
        msg_req = 1'b0;
        wait_start(10);
        score_req = 1'b1; score_val = 8'd77;
        tick();
        score_req = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lit("t6_reset", pk(0, 0, 0, 0, 8'h00, 0));
        repeat (40) tick();
        lit("t6_no_start", pk(0, 0, 0, 0, 8'h00, 0));

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
